hex_display_scheduler: RTL
==========================

// Module: hex_display_scheduler
// PURPOSE
//   Shares the six-digit seven-segment display between REQ_N requesters (CPU port, debug, switches).
//   A round-robin scheduler grants the display to one requester for a fixed time slot.
//   It latches that requester's 24-bit number and decimal-point mask, then rotates.
//   Its outputs drive the per-digit display_static_digit decoders and the dot segments directly.
// PARAMETERS
//   REQ_N        3           number of requesters, >= 1
//   HOLD_CYCLES  50_000_000  cycles a granted value is guaranteed on display (1 s @ 50 MHz), >= 1
// PORTS
//   clk          in   1         system clock (max10_clk1_50)
//   reset        in   1         synchronous, active-high
//   req          in   REQ_N     per-requester display request, level
//   req_number   in   REQ_N*24  requester i number at [i*24 +: 24]
//   req_dots     in   REQ_N*6   requester i dot mask at [i*6 +: 6]; 1 = dot lit
//   freeze       in   1         1 = current slot never expires (debug hold)
//   ack          out  REQ_N     one-cycle pulse: requester's value now on display
//   number       out  24        displayed number; nibble k drives digit k
//   dots         out  6         displayed dot mask, active-high; the board inverts it
//   owner        out  OW        index of the current owner; OW = max(1, $clog2(REQ_N))
//   owner_valid  out  1         1 once any value has been granted since reset
// BEHAVIOUR
//   Reset
//     - Effective at the clock edge while reset = 1; aborts any slot in progress.
//     - Outputs: number = 0, dots = 0, ack = 0, owner = 0, owner_valid = 0.
//     - Internal: state = IDLE, rr_last = REQ_N-1, so requester 0 wins first.
//   States
//     - IDLE: if |req, then grant <= rr_pick and go to LOAD; else stay.
//       The display holds its last value.
//     - LOAD (1 cycle): at the edge leaving LOAD:
//         number <= req_number[grant], dots <= req_dots[grant]
//         owner <= grant, rr_last <= grant, owner_valid <= 1
//         ack[grant] <= 1; cnt <= HOLD_CYCLES-1; go to HOLD
//     - HOLD:
//         freeze = 1: cnt holds and the state stays HOLD.
//         cnt != 0: cnt decrements.
//         cnt == 0 and |req: grant <= rr_pick, go to LOAD.
//         cnt == 0 and no req: go to IDLE.
//   Arbitration
//     - rr_pick is the first i with req[i] = 1, scanning rr_last+1, rr_last+2, ... mod REQ_N.
//     - The current owner is considered last, so a lone requester regains the display.
//     - Arbitration is combinational on req in the cycle of the decision edge.
//   Timing
//     - req rises in IDLE and is sampled at edge E.
//     - At edge E+1 number/dots update and ack is high for the cycle after E+1.
//     - With requests continuously pending, consecutive updates are HOLD_CYCLES+1 cycles apart.
//     - ack is a single-cycle pulse.
//   Handshake
//     - Requester holds req, req_number and req_dots stable until it sees ack.
//     - It deasserts req in the ack cycle unless it wants another slot.
//     - A req still high at the next decision point is eligible again.
//     - If req drops while in LOAD, the data on the bus is latched and ack pulses anyway; no error.
//     - req_number and req_dots are sampled only at the LOAD edge.
//       Changes during HOLD do not affect the display.
//   Other rules
//     - freeze does not block the LOAD that is already scheduled.
//     - Releasing freeze while cnt == 0 allows the decision at the next edge.
//     - cnt width is $clog2(HOLD_CYCLES+1); no wrap (it stops at 0).
//     - REQ_N = 1: owner is always 0; rotation degenerates to repeated grants of requester 0.
// TESTING (REQ_N = 3, HOLD_CYCLES = 4)
//   1. Reset, then req = 000 for 20 cycles
//      -> number = 0, dots = 0, ack = 0, owner_valid = 0 throughout.
//   2. req = 010, req_number[1] = 24'h12_3456, req_dots[1] = 6'h21
//      -> 2 edges later: number = 123456, dots = 21, owner = 1, ack = 010 for exactly 1 cycle.
//   3. req = 111 held continuously
//      -> owners 0, 1, 2, 0, ...; ack pulses are 5 cycles apart; each number matches its source.
//   4. Only req[2] held
//      -> repeated grants to 2 every 5 cycles; drop req in the ack cycle -> IDLE, display keeps its value.
//   5. freeze = 1 during HOLD with req = 101 pending
//      -> no ack and no change for 30 cycles.
//      -> freeze = 0 -> next grant goes to the rotation successor.
//   6. Assert reset mid-HOLD and mid-LOAD
//      -> next cycle all outputs at reset values, no ack.
//      -> after release, requester 0 wins the first grant.

Source files
------------

// File: rtl/hex_display_scheduler.sv
// Round-robin owner of the six-digit display: grants one requester per time slot,
// latches its number/dot mask and pulses ack. States: IDLE | idle, LOAD | latch winner, HOLD | slot timer.
module hex_display_scheduler #(
    parameter int REQ_N       = 3,
    parameter int HOLD_CYCLES = 50_000_000,
    localparam int OW = (REQ_N > 1) ? $clog2(REQ_N) : 1,
    localparam int CW = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [REQ_N-1:0]    req_i,
    input  logic [REQ_N*24-1:0] req_number_i,
    input  logic [REQ_N*6-1:0]  req_dots_i,
    input  logic                freeze_i,
    output logic [REQ_N-1:0]    ack_o,
    output logic [23:0]         number_o,
    output logic [5:0]          dots_o,
    output logic [OW-1:0]       owner_o,
    output logic                owner_valid_o
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    grant_q, grant_d;
    logic [OW-1:0]    rr_last_q, rr_last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [23:0]      number_q, number_d;
    logic [5:0]       dots_q, dots_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic             owner_valid_q, owner_valid_d;
    logic [REQ_N-1:0] ack_q, ack_d;

    logic [OW-1:0]    rr_pick;
    logic             any_req;
    logic [23:0]      sel_number;
    logic [5:0]       sel_dots;

    assign any_req = |req_i;

    // Scan starts just after the last owner, so the owner itself is checked last.
    always_comb begin
        int         idx;
        logic       found;
        logic [REQ_N-1:0] req_sh;
        rr_pick = '0;
        found   = 1'b0;
        idx     = 0;
        req_sh  = '0;
        for (int k = 1; k <= REQ_N; k++) begin
            idx = int'(rr_last_q) + k;
            if (idx >= REQ_N) idx = idx - REQ_N;
            req_sh = req_i >> idx;
            if (!found && req_sh[0]) begin
                rr_pick = OW'(idx);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        sel_number = '0;
        sel_dots   = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (grant_q == OW'(i)) begin
                sel_number = req_number_i[i*24 +: 24];
                sel_dots   = req_dots_i[i*6 +: 6];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_last_q     <= OW'(REQ_N - 1);
            cnt_q         <= '0;
            number_q      <= '0;
            dots_q        <= '0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            ack_q         <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_last_q     <= rr_last_d;
            cnt_q         <= cnt_d;
            number_q      <= number_d;
            dots_q        <= dots_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            ack_q         <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = LOAD;
            LOAD:    state_d = HOLD;
            HOLD:    if (!freeze_i && cnt_q == '0) state_d = any_req ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d       = grant_q;
        rr_last_d     = rr_last_q;
        cnt_d         = cnt_q;
        number_d      = number_q;
        dots_d        = dots_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        ack_d         = '0;
        case (state_q)
            IDLE: begin
                if (any_req) grant_d = rr_pick;
            end
            LOAD: begin
                number_d      = sel_number;
                dots_d        = sel_dots;
                owner_d       = grant_q;
                rr_last_d     = grant_q;
                owner_valid_d = 1'b1;
                ack_d         = REQ_N'(1) << grant_q;
                cnt_d         = CW'(HOLD_CYCLES - 1);
            end
            HOLD: begin
                if (!freeze_i) begin
                    if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                    else if (any_req) grant_d = rr_pick;
                end
            end
            default: ;
        endcase
    end

    assign ack_o         = ack_q;
    assign number_o      = number_q;
    assign dots_o        = dots_q;
    assign owner_o       = owner_q;
    assign owner_valid_o = owner_valid_q;

endmodule
